// File: rtl/uart_digit_rx.sv
// uart_digit_rx: UART 8N1 receiver for the PMOD RX pin, with ASCII digit detection
// for the seven-segment display path.
//
// Parameters
//   CLK_HZ        system clock frequency
//   BAUD          line rate
//   CLKS_PER_BIT  clocks per bit (override for simulation)
//
// Ports
//   CLK100MHZ        in   system clock, rising edge
//   rst              in   synchronous reset, active-high
//   uart_rx_of_pmod  in   raw asynchronous UART line, idle high
//   rx_data          out  last good byte, held until the next good byte
//   rx_valid         out  1-cycle pulse when rx_data updates
//   digit            out  rx_data-0x30 for '0'..'9', held otherwise
//   digit_valid      out  1-cycle pulse alongside rx_valid, digits only
//   frame_err        out  1-cycle pulse when the stop bit is sampled low
//   busy             out  high whenever the receiver is not idle
module uart_digit_rx #(
  parameter int unsigned CLK_HZ       = 100_000_000,
  parameter int unsigned BAUD         = 9600,
  parameter int unsigned CLKS_PER_BIT = CLK_HZ / BAUD
) (
  input  logic       CLK100MHZ,
  input  logic       rst,
  input  logic       uart_rx_of_pmod,
  output logic [7:0] rx_data,
  output logic       rx_valid,
  output logic [3:0] digit,
  output logic       digit_valid,
  output logic       frame_err,
  output logic       busy
);

  localparam int unsigned CW = (CLKS_PER_BIT > 1) ? $clog2(CLKS_PER_BIT) : 1;
  localparam logic [CW-1:0] HALF_M1 = CW'(CLKS_PER_BIT / 2 - 1);
  localparam logic [CW-1:0] FULL_M1 = CW'(CLKS_PER_BIT - 1);

  typedef enum logic [2:0] {
    IDLE,
    START,
    DATA,
    STOP,
    WAIT_HIGH
  } state_t;

  state_t        state;
  logic          sync1;
  logic          rxs;
  logic [CW-1:0] cnt;
  logic [2:0]    bit_idx;
  logic [7:0]    shreg;

  always_ff @(posedge CLK100MHZ) begin
    if (rst) begin
      sync1       <= 1'b1;
      rxs         <= 1'b1;
      state       <= IDLE;
      cnt         <= '0;
      bit_idx     <= '0;
      shreg       <= '0;
      rx_data     <= '0;
      rx_valid    <= 1'b0;
      digit       <= '0;
      digit_valid <= 1'b0;
      frame_err   <= 1'b0;
      busy        <= 1'b0;
    end else begin
      sync1       <= uart_rx_of_pmod;
      rxs         <= sync1;
      rx_valid    <= 1'b0;
      digit_valid <= 1'b0;
      frame_err   <= 1'b0;

      case (state)
        IDLE: begin
          if (!rxs) begin
            state <= START;
            cnt   <= '0;
            busy  <= 1'b1;
          end
        end

        START: begin
          if (cnt == HALF_M1) begin
            cnt <= '0;
            if (!rxs) begin
              state   <= DATA;
              bit_idx <= '0;
            end else begin
              // Start bit gone by mid-bit: treat as a glitch.
              state <= IDLE;
              busy  <= 1'b0;
            end
          end else begin
            cnt <= cnt + 1'b1;
          end
        end

        DATA: begin
          // Sampling point sits one full bit after mid start, i.e. mid data bit.
          if (cnt == FULL_M1) begin
            cnt   <= '0;
            shreg <= {rxs, shreg[7:1]};
            if (bit_idx == 3'd7) state <= STOP;
            else                 bit_idx <= bit_idx + 1'b1;
          end else begin
            cnt <= cnt + 1'b1;
          end
        end

        STOP: begin
          if (cnt == FULL_M1) begin
            cnt <= '0;
            if (rxs) begin
              rx_data  <= shreg;
              rx_valid <= 1'b1;
              if (shreg >= 8'h30 && shreg <= 8'h39) begin
                digit       <= shreg[3:0];
                digit_valid <= 1'b1;
              end
              // Leave at mid stop so a start edge half a bit later is caught.
              state <= IDLE;
              busy  <= 1'b0;
            end else begin
              frame_err <= 1'b1;
              state     <= WAIT_HIGH;
            end
          end else begin
            cnt <= cnt + 1'b1;
          end
        end

        WAIT_HIGH: begin
          // A break or stuck-low line must not retrigger reception.
          if (rxs) begin
            state <= IDLE;
            cnt   <= '0;
            busy  <= 1'b0;
          end
        end

        default: begin
          state <= IDLE;
          cnt   <= '0;
          busy  <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_uart_digit_rx.sv
// tb_uart_digit_rx: scoreboard bench for uart_digit_rx with a 16-clock bit period.
module tb_uart_digit_rx;

  localparam int unsigned CPB = 16;

  logic       clk;
  logic       rst;
  logic       rx_line;
  logic [7:0] rx_data;
  logic       rx_valid;
  logic [3:0] digit;
  logic       digit_valid;
  logic       frame_err;
  logic       busy;

  uart_digit_rx #(
    .CLK_HZ      (100_000_000),
    .BAUD        (9600),
    .CLKS_PER_BIT(CPB)
  ) dut (
    .CLK100MHZ      (clk),
    .rst            (rst),
    .uart_rx_of_pmod(rx_line),
    .rx_data        (rx_data),
    .rx_valid       (rx_valid),
    .digit          (digit),
    .digit_valid    (digit_valid),
    .frame_err      (frame_err),
    .busy           (busy)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic       is_err;
    logic [7:0] data;
    logic       dv;
    logic [3:0] dig;
  } exp_t;

  exp_t sb[$];
  int   n_vec = 0;
  int   n_err = 0;
  logic [7:0] model_data = 8'h00;
  logic [3:0] model_digit = 4'h0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, got, exp, $time);
    end
  endtask

  task automatic drive_bit(input logic b);
    rx_line = b;
    repeat (CPB) @(negedge clk);
  endtask

  // Push the expected outcome, then drive the full frame.
  task automatic send_byte(input logic [7:0] b, input logic stop);
    exp_t e;
    if (stop) begin
      model_data = b;
      e.dv = (b >= 8'h30 && b <= 8'h39);
      if (e.dv) model_digit = b[3:0];
      e.is_err = 1'b0;
    end else begin
      e.dv = 1'b0;
      e.is_err = 1'b1;
    end
    e.data = model_data;
    e.dig  = model_digit;
    sb.push_back(e);
    drive_bit(1'b0);
    for (int i = 0; i < 8; i++) drive_bit(b[i]);
    drive_bit(stop);
  endtask

  // Output monitor: every pulse must match the oldest pending expectation.
  always @(negedge clk) begin
    if (!rst && (rx_valid || frame_err || digit_valid)) begin
      if (sb.size() == 0) begin
        check("unexpected_pulse", {29'd0, rx_valid, frame_err, digit_valid}, 32'd0);
      end else begin
        exp_t e;
        e = sb.pop_front();
        check("rx_valid", {31'd0, rx_valid}, {31'd0, ~e.is_err});
        check("frame_err", {31'd0, frame_err}, {31'd0, e.is_err});
        check("digit_valid", {31'd0, digit_valid}, {31'd0, e.dv});
        check("rx_data", {24'd0, rx_data}, {24'd0, e.data});
        check("digit", {28'd0, digit}, {28'd0, e.dig});
      end
    end
  end

  task automatic drain(input string tag);
    int n = 0;
    while (sb.size() != 0 && n < 4 * CPB) begin
      @(negedge clk);
      n++;
    end
    check(tag, sb.size(), 0);
  endtask

  initial begin
    #1_000_000;
    $display("FAIL timeout: bench did not finish");
    $fatal(1, "timeout");
  end

  initial begin
    rst     = 1'b1;
    rx_line = 1'b1;
    repeat (3) @(negedge clk);
    check("reset_rx_data", {24'd0, rx_data}, 32'd0);
    check("reset_digit", {28'd0, digit}, 32'd0);
    check("reset_busy", {31'd0, busy}, 32'd0);
    check("reset_pulses", {29'd0, rx_valid, digit_valid, frame_err}, 32'd0);
    rst = 1'b0;
    repeat (4) @(negedge clk);

    // '5' then 'A': digit holds 5 across the non-digit byte.
    send_byte(8'h35, 1'b1);
    drive_bit(1'b1);
    drain("drain_5");
    send_byte(8'h41, 1'b1);
    drive_bit(1'b1);
    drain("drain_A");

    // Short low glitch: no pulses, busy clears by mid-bit.
    rx_line = 1'b0;
    repeat (CPB / 4) @(negedge clk);
    rx_line = 1'b1;
    repeat (CPB) @(negedge clk);
    check("glitch_busy", {31'd0, busy}, 32'd0);

    // Framing error with the line held low afterwards.
    send_byte(8'h37, 1'b0);
    rx_line = 1'b0;
    repeat (3 * CPB) @(negedge clk);
    check("break_busy", {31'd0, busy}, 32'd1);
    check("break_rx_data", {24'd0, rx_data}, 32'h41);
    rx_line = 1'b1;
    repeat (4) @(negedge clk);
    check("break_release_busy", {31'd0, busy}, 32'd0);
    drain("drain_ferr");
    repeat (CPB) @(negedge clk);

    // Back-to-back digits with no idle gap.
    send_byte(8'h31, 1'b1);
    send_byte(8'h39, 1'b1);
    drive_bit(1'b1);
    drain("drain_b2b");

    // Reset mid data bit 4 of '3', then a clean '3'.
    begin
      logic [7:0] b3;
      b3 = 8'h33;
      drive_bit(1'b0);
      for (int i = 0; i < 4; i++) drive_bit(b3[i]);
      rx_line = b3[4];
      repeat (CPB / 2) @(negedge clk);
      check("midframe_busy", {31'd0, busy}, 32'd1);
      rst = 1'b1;
      rx_line = 1'b1;
      model_data  = 8'h00;
      model_digit = 4'h0;
      repeat (2) @(negedge clk);
      rst = 1'b0;
      repeat (3 * CPB) @(negedge clk);
      check("post_rst_rx_data", {24'd0, rx_data}, 32'd0);
      check("post_rst_digit", {28'd0, digit}, 32'd0);
      check("post_rst_busy", {31'd0, busy}, 32'd0);
      send_byte(b3, 1'b1);
      drive_bit(1'b1);
      drain("drain_3");
      check("final_digit", {28'd0, digit}, 32'd3);
    end

    repeat (2 * CPB) @(negedge clk);
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
